// File: rtl/ahb_slave_memmodel.sv
// ahb_slave_memmodel: AHB-Lite slave memory with byte lanes, wait states and ERROR responses when AHB_SLAVE_MEM_ERRRESP_EN is defined
module ahb_slave_memmodel #(
    parameter int AWIDTH      = 12,
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic              HSEL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADYIN,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DWIDTH-1:0] HRDATA
);
    localparam int NB   = DWIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IXW-1:0]    idx_q, idx_d, idx_c;
    logic [NB-1:0]     lanes_q, lanes_d, lanes_c;
    logic              write_q, write_d;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] bmask;
    logic              accept, err, open;
    logic              unused_ok;
    int                word_i, off_i, size_i, lo_i;

    assign unused_ok = ^{HBURST, HTRANS[0]};
    assign accept    = HSEL && HREADYIN && HTRANS[1];
    assign open      = (state_q == S_IDLE) || (state_q == S_XFER) || (state_q == S_ERR2);

    // Address-phase decode: word index, aligned lane mask and error classification
    always_comb begin
        word_i = int'(HADDR[AWIDTH-1:OFFW]);
        off_i  = int'(HADDR[OFFW-1:0]);
        size_i = (int'(HSIZE) > OFFW) ? OFFW : int'(HSIZE);
        lo_i   = off_i & ~((1 << size_i) - 1);
`ifdef AHB_SLAVE_MEM_ERRRESP_EN
        err    = (word_i >= DEPTH) || (int'(HSIZE) > OFFW) || (off_i != lo_i);
        idx_c  = IXW'(word_i);
`else
        err    = 1'b0;
        idx_c  = IXW'(word_i % DEPTH);
`endif
        for (int b = 0; b < NB; b++)
            lanes_c[b] = (b >= lo_i) && (b < lo_i + (1 << size_i));
    end

    // Next-state: wait countdown, two-cycle error, otherwise accept the next address phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        write_d = write_q;
        if (state_q == S_WAIT) begin
            state_d = (cnt_q == 4'd0) ? S_XFER : S_WAIT;
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (open) begin
            state_d = !accept ? S_IDLE : err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_XFER;
            if (accept) begin
                idx_d   = idx_c;
                lanes_d = lanes_c;
                write_d = HWRITE && !err;
                cnt_d   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
            end
        end
    end

    // Bus outputs; read data only during a read XFER, unselected lanes zero
    always_comb begin
        for (int b = 0; b < NB; b++)
            bmask[8*b +: 8] = {8{lanes_q[b]}};
        HREADYOUT = (state_q != S_WAIT) && (state_q != S_ERR1);
`ifdef AHB_SLAVE_MEM_ERRRESP_EN
        HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
        HRESP     = 1'b0;
`endif
        HRDATA    = (state_q == S_XFER && !write_q) ? (mem[idx_q] & bmask) : '0;
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lanes_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            write_q <= write_d;
        end
    end

    // Byte-lane write at the closing edge of a write XFER; reset discards it
    always_ff @(posedge HCLK) begin
        if (HRESETN && state_q == S_XFER && write_q)
            for (int b = 0; b < NB; b++)
                if (lanes_q[b])
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_ahb_slave_memmodel.sv
// tb_ahb_slave_memmodel: three slaves (0, 3, 2 wait states) on one bus, checked against an array model
module tb_ahb_slave_memmodel;
    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  hsel;
    logic [12:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [2:0]  ro, rr;
    logic [31:0] rd [3];
    int          sel = 0;
    int          errors = 0;
    int          checks = 0;
    bit   [31:0] m [3][1024];
    int          ws [3] = '{0, 3, 2};

    always #5 clk = ~clk;
    assign hready = ro[sel];

    ahb_slave_memmodel #(.AWIDTH(13), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETN(rstn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADYIN(hready),
        .HREADYOUT(ro[0]), .HRESP(rr[0]), .HRDATA(rd[0]));
    ahb_slave_memmodel #(.AWIDTH(13), .WAIT_STATES(3)) u1 (
        .HCLK(clk), .HRESETN(rstn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADYIN(hready),
        .HREADYOUT(ro[1]), .HRESP(rr[1]), .HRDATA(rd[1]));
    ahb_slave_memmodel #(.AWIDTH(13), .WAIT_STATES(2)) u2 (
        .HCLK(clk), .HRESETN(rstn), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADYIN(hready),
        .HREADYOUT(ro[2]), .HRESP(rr[2]), .HRDATA(rd[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One NONSEQ transfer: address phase now, data phase until HREADYOUT is seen high
    task automatic xfer(input int d, input logic wr, input logic [12:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rdat, output int low,
                        output logic rlow, output logic rfin);
        sel = d;
        hsel = 3'b000;
        hsel[d] = 1'b1;
        haddr = a;
        htrans = 2'b10;
        hwrite = wr;
        hsize = sz;
        @(negedge clk);
        hsel = 3'b000;
        htrans = 2'b00;
        hwdata = wd;
        low = 0;
        rlow = 1'b0;
        while (ro[d] !== 1'b1 && low < 40) begin
            low++;
            rlow |= rr[d];
            @(negedge clk);
        end
        rdat = rd[d];
        rfin = rr[d];
    endtask

    // Transfer checked against the model: latency, OKAY, and read data of the addressed lanes
    task automatic op(input int d, input logic wr, input logic [12:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input string tag, output logic [31:0] r);
        logic [31:0] msk;
        int low, w, off;
        logic rl, rf;
        w = (int'(a) >> 2) % 1024;
        off = int'(a) % 4;
        msk = '0;
        for (int i = 0; i < (1 << sz); i++) msk[8*(off+i) +: 8] = 8'hFF;
        xfer(d, wr, a, sz, wd, r, low, rl, rf);
        chk({tag, ".wait"}, 32'(low), 32'(ws[d]));
        chk({tag, ".resp"}, 32'(rl | rf), 32'd0);
        if (wr) m[d][w] = (m[d][w] & ~msk) | (wd & msk);
        else chk({tag, ".data"}, r, m[d][w] & msk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int low, d, sz, off;
        logic rl, rf;
        rstn = 1'b0;
        hsel = '0;
        haddr = '0;
        htrans = '0;
        hwrite = 1'b0;
        hsize = '0;
        hwdata = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst.ready", 32'(ro[k]), 32'd1);
            chk("rst.resp", 32'(rr[k]), 32'd0);
            chk("rst.rdata", rd[k], 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 64; w++)
                op(k, 1'b1, 13'(w * 4), 3'd2, $urandom, "init", r);

        op(0, 1'b1, 13'h010, 3'd2, 32'hDEADBEEF, "word.wr", r);
        op(0, 1'b0, 13'h010, 3'd2, 32'h0, "word.rd", r);
        chk("word.const", r, 32'hDEADBEEF);

        op(0, 1'b1, 13'h020, 3'd2, 32'h11223344, "lane.wr", r);
        op(0, 1'b1, 13'h022, 3'd0, 32'h55AA5555, "lane.byte", r);
        op(0, 1'b0, 13'h020, 3'd2, 32'h0, "lane.rd", r);
        chk("lane.const", r, 32'h11AA3344);

        op(1, 1'b0, 13'h004, 3'd2, 32'h0, "ws3.rd", r);

        op(0, 1'b1, 13'h030, 3'd2, 32'h00000055, "b2b.wr", r);
        op(0, 1'b0, 13'h030, 3'd2, 32'h0, "b2b.rd", r);
        chk("b2b.const", r, 32'h00000055);

        xfer(0, 1'b1, 13'h1000, 3'd2, 32'hCAFEF00D, r, low, rl, rf);
`ifdef AHB_SLAVE_MEM_ERRRESP_EN
        chk("err.low", 32'(low), 32'd1);
        chk("err.resp1", 32'(rl), 32'd1);
        chk("err.resp2", 32'(rf), 32'd1);
`else
        chk("err.low", 32'(low), 32'd0);
        chk("err.resp", 32'(rl | rf), 32'd0);
        m[0][0] = 32'hCAFEF00D;
`endif
        op(0, 1'b0, 13'h000, 3'd2, 32'h0, "err.word0", r);

        sel = 2;
        hsel = 3'b100;
        haddr = 13'h040;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize = 3'd2;
        @(negedge clk);
        hsel = 3'b000;
        htrans = 2'b00;
        hwdata = 32'h12345678;
        chk("mid.low", 32'(ro[2]), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid.ready", 32'(ro[2]), 32'd1);
        chk("mid.resp", 32'(rr[2]), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        op(2, 1'b0, 13'h040, 3'd2, 32'h0, "mid.rd", r);

        for (int n = 0; n < 300; n++) begin
            d = $urandom_range(0, 2);
            sz = $urandom_range(0, 2);
            off = $urandom_range(0, 3) & ~((1 << sz) - 1);
            op(d, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 63) * 4 + off), 3'(sz),
               $urandom, "rand", r);
        end

        hsel = '0;
        htrans = '0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
